pmod_cls_spi_responder: RTL and testbench
=========================================

PMOD_CLS_SPI_RESPONDER -- requirements
Module: pmod_cls_spi_responder

Interface
REQ-001 Parameter parm_sync_stages, default 2, meaning flip-flop depth of the SCK/CSN/COPI input synchronizers (legal 2..3).
REQ-002 i_clk_20mhz  in  1  sole clock; SPI bus oversampled on every edge (SCK at most 1/8 of clock).
REQ-003 i_rst_20mhz  in  1  reset, synchronous, active-high.
REQ-004 ei_sck  in  1  SPI clock from the controller, mode 0.
REQ-005 ei_csn  in  1  chip select, active-low.
REQ-006 ei_copi  in  1  controller-out data, MSB first.
REQ-007 eo_cipo_o  out  1  constant 0.
REQ-008 eo_cipo_t  out  1  constant 1; CIPO always tri-stated, because the CLS is write-only.
REQ-009 o_byte_valid  out  1  one-cycle strobe, with a received byte on o_byte.
REQ-010 o_byte  out  8  last received byte; held until the next strobe.
REQ-011 o_line1, o_line2  out  t_pmod_cls_ascii_line_16  display buffer rows 0 and 1.
REQ-012 o_evt_clear  out  1  one-cycle strobe when a clear command completes.
REQ-013 o_evt_cursor  out  1  one-cycle strobe when a cursor-position command completes.
REQ-014 o_err_frame  out  1  one-cycle strobe when CSN deasserts with 1..7 bits pending.

Function
REQ-015 Inputs SHALL pass through parm_sync_stages flip-flops.
REQ-016 Edge detection SHALL operate on the synchronized signals only.
REQ-017 While synchronized CSN is low, each synchronized SCK rising edge SHALL shift COPI into an 8-bit shift register, MSB first.
REQ-018 The bit counter SHALL be 3 bits wide and wrap from 7 to 0.
REQ-019 On the 8th rising edge, o_byte_valid SHALL assert exactly one cycle after the edge-detect cycle; o_byte SHALL update in the same cycle.
REQ-020 A CSN rising edge SHALL clear the bit counter and the shift register.
REQ-021 If the bit counter is nonzero at that CSN rising edge, o_err_frame SHALL strobe and the partial byte SHALL be discarded.
REQ-022 SCK edges while CSN is high SHALL be ignored.
REQ-023 A CSN falling edge SHALL not reset the parser; escape sequences may span chip-select frames.
REQ-024 The parser SHALL consume each o_byte_valid byte in the same cycle, using states ST_TEXT, ST_ESC, ST_CSI_P1, ST_CSI_P2.
REQ-025 ST_TEXT, byte 0x1B: go to ST_ESC.
REQ-026 ST_TEXT, byte 0x20..0x7E, cursor column 0..15: write the byte to the current row at that column, then increment the column.
REQ-027 ST_TEXT, byte 0x20..0x7E, cursor column 16: discard the byte; the column saturates at 16.
REQ-028 ST_TEXT, any other byte: ignore it.
REQ-029 ST_ESC, byte 0x5B ('['): clear p1 and p2 to 0 and go to ST_CSI_P1.
REQ-030 ST_ESC, any other byte: return to ST_TEXT with the byte dropped.
REQ-031 ST_CSI_P1/P2, digit '0'..'9': update the current parameter as param*10+digit.
REQ-032 The parameter arithmetic SHALL be 7 bits wide and saturate at 99.
REQ-033 ST_CSI_P1, byte ';' (0x3B): go to ST_CSI_P2.
REQ-034 ST_CSI_P2, byte ';': ignore it.
REQ-035 Final byte 'j' (0x6A): fill both rows with 0x20, set cursor to (0,0), strobe o_evt_clear, return to ST_TEXT.
REQ-036 Final byte 'H' (0x48): set row to p1 (values >1 clamp to 1), set column to p2 (values >16 clamp to 16), strobe o_evt_cursor, return to ST_TEXT.
REQ-037 Any other byte 0x40..0x7E in a CSI state (e.g. 'h', 'e'): accept as a no-op and return to ST_TEXT.
REQ-038 Any other byte in a CSI state: abort to ST_TEXT with no effect.
REQ-039 Byte 0x1B in any CSI state: restart at ST_ESC.
REQ-040 Rows 0 and 1 SHALL map to o_line1 and o_line2.
REQ-041 Character index 0 of each row SHALL occupy the most-significant byte of the line vector.
REQ-042 Row outputs SHALL be registered and SHALL update one cycle after the o_byte_valid cycle.

Reset
REQ-043 Reset SHALL clear the synchronizers to CSN=1, SCK=0, COPI=0.
REQ-044 Reset SHALL clear the shift register, bit counter, o_byte, p1 and p2 to 0.
REQ-045 Reset SHALL set the parser state to ST_TEXT and the cursor to (0,0).
REQ-046 Reset SHALL fill both rows with 0x20 and drive all strobes to 0.
REQ-047 Reset asserted mid-byte or mid-sequence SHALL discard all partial state; the first post-reset byte SHALL be parsed from ST_TEXT.

Structure
REQ-048 Type t_pmod_cls_ascii_line_16 SHALL be reused from pmod_stand_spi_solo_pkg.
REQ-049 Constants c_cls_esc, c_cls_csi, c_cls_sep, c_cls_fin_clear, c_cls_fin_cursor, c_cls_cols=16 and the parser state enum SHALL be added to that package.
REQ-050 The synchronizer, edge detect and deserializer SHALL be one sub-module, pmod_spi_responder_deser.
REQ-051 The command parser and display buffer SHALL reside in the top module.

Verification
REQ-052 Send bytes 1B 5B 6A -> o_evt_clear once; both lines all 0x20; cursor (0,0).
REQ-053 Send 1B 5B 30 3B 30 48 then "HELLO" -> o_line1 starts 48 45 4C 4C 4F, remainder 0x20; o_line2 unchanged.
REQ-054 Send 1B 5B 31 3B 31 34 48 then "ABCD" -> o_line2[14]=41, o_line2[15]=42; 43 and 44 discarded.
REQ-055 Raise CSN after 5 bits of 0xA5, then send a full 0x41 -> o_err_frame once; next o_byte=0x41; text write at the current cursor.
REQ-056 Assert reset after 1B 5B 31, then send "Z" -> 0x5A written to o_line1[0]; no cursor event.
REQ-057 Split 1B | 5B 6A across two CSN frames, with SCK = clock/32 -> clear takes effect; o_byte_valid exactly 1 cycle after each 8th synchronized rising edge.

Source files
------------

// File: rtl/pmod_stand_spi_solo_pkg.sv
// -----------------------------------------------------------------------------
// pmod_stand_spi_solo_pkg
// Shared types and constants for the stand-alone SPI responder that emulates a
// Digilent PmodCLS character display.
//   t_pmod_cls_ascii_line_16 : one 16-character display row; character index 0
//                              sits in the most-significant byte.
//   c_cls_*                  : bytes recognised by the command parser.
//   t_cls_state              : command parser states.
//   f_cls_param_accum        : decimal parameter accumulate with saturation.
// -----------------------------------------------------------------------------
package pmod_stand_spi_solo_pkg;

   typedef logic [15:0][7:0] t_pmod_cls_ascii_line_16;

   localparam logic [7:0] c_cls_esc        = 8'h1B;
   localparam logic [7:0] c_cls_csi        = 8'h5B;  // '['
   localparam logic [7:0] c_cls_sep        = 8'h3B;  // ';'
   localparam logic [7:0] c_cls_fin_clear  = 8'h6A;  // 'j'
   localparam logic [7:0] c_cls_fin_cursor = 8'h48;  // 'H'
   localparam int         c_cls_cols       = 16;

   localparam logic [7:0] c_cls_space      = 8'h20;
   localparam logic [6:0] c_cls_param_max  = 7'd99;
   localparam t_pmod_cls_ascii_line_16 c_cls_blank_line = {16{8'h20}};

   typedef enum logic [1:0] {
      ST_TEXT   = 2'd0,
      ST_ESC    = 2'd1,
      ST_CSI_P1 = 2'd2,
      ST_CSI_P2 = 2'd3
   } t_cls_state;

   // param*10 + digit, computed wide enough that it cannot wrap before the
   // saturation compare; the stored parameter is 7 bits and never exceeds 99.
   function automatic logic [6:0] f_cls_param_accum(input logic [6:0] param,
                                                    input logic [3:0] digit);
      logic [10:0] wide;
      wide = 11'(param) * 11'd10 + 11'(digit);
      if (wide > 11'(c_cls_param_max)) begin
         return c_cls_param_max;
      end
      return wide[6:0];
   endfunction

endpackage

// File: rtl/pmod_spi_responder_deser.sv
// -----------------------------------------------------------------------------
// pmod_spi_responder_deser
// SPI mode-0 receive path: input synchronizers, edge detection on the
// synchronized signals and an MSB-first 8-bit deserializer.
//   clk_i, rst_i   : system clock, synchronous active-high reset
//   sck_i, csn_i,
//   copi_i         : raw SPI pins from the controller
//   byte_valid_o   : one-cycle strobe, byte_o valid with it
//   byte_o         : last complete byte, held until the next strobe
//   err_frame_o    : one-cycle strobe when CSN rises with 1..7 bits pending
// -----------------------------------------------------------------------------
module pmod_spi_responder_deser #(
   parameter int sync_stages = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sck_i,
   input  logic       csn_i,
   input  logic       copi_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       err_frame_o
);

   logic [sync_stages-1:0] sck_sync_q;
   logic [sync_stages-1:0] csn_sync_q;
   logic [sync_stages-1:0] copi_sync_q;

   logic       sck_prev_q;
   logic       csn_prev_q;
   logic [7:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] byte_q;
   logic       byte_valid_q;
   logic       err_frame_q;

   logic sck_s, csn_s, copi_s;
   logic sck_rise, csn_rise;
   logic [7:0] shift_next;

   assign sck_s  = sck_sync_q[sync_stages-1];
   assign csn_s  = csn_sync_q[sync_stages-1];
   assign copi_s = copi_sync_q[sync_stages-1];

   assign sck_rise   = sck_s & ~sck_prev_q;
   assign csn_rise   = csn_s & ~csn_prev_q;
   assign shift_next = {shift_q[6:0], copi_s};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // Idle bus levels, so no spurious edge is seen as reset releases.
         sck_sync_q   <= '0;
         csn_sync_q   <= '1;
         copi_sync_q  <= '0;
         sck_prev_q   <= 1'b0;
         csn_prev_q   <= 1'b1;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         err_frame_q  <= 1'b0;
      end else begin
         sck_sync_q   <= {sck_sync_q[sync_stages-2:0], sck_i};
         csn_sync_q   <= {csn_sync_q[sync_stages-2:0], csn_i};
         copi_sync_q  <= {copi_sync_q[sync_stages-2:0], copi_i};
         sck_prev_q   <= sck_s;
         csn_prev_q   <= csn_s;
         byte_valid_q <= 1'b0;
         err_frame_q  <= 1'b0;

         if (csn_rise) begin
            // End of frame: any partial byte is thrown away.
            if (bit_cnt_q != 3'd0) begin
               err_frame_q <= 1'b1;
            end
            bit_cnt_q <= '0;
            shift_q   <= '0;
         end else if (!csn_s && sck_rise) begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;  // wraps 7 -> 0
            if (bit_cnt_q == 3'd7) begin
               byte_q       <= shift_next;
               byte_valid_q <= 1'b1;
            end
         end
      end
   end

   assign byte_valid_o = byte_valid_q;
   assign byte_o       = byte_q;
   assign err_frame_o  = err_frame_q;

endmodule

// File: rtl/pmod_cls_spi_responder.sv
// -----------------------------------------------------------------------------
// pmod_cls_spi_responder
// Write-only PmodCLS emulation: receives bytes over SPI, interprets printable
// text and the ESC [ ... j / ESC [ r ; c H commands, and keeps a two-row
// 16-character display buffer.
//   i_clk_20mhz, i_rst_20mhz : clock, synchronous active-high reset
//   ei_sck, ei_csn, ei_copi  : SPI bus from the controller (mode 0)
//   eo_cipo_o, eo_cipo_t     : CIPO pad driver, permanently tri-stated
//   o_byte_valid, o_byte     : received byte strobe and data
//   o_line1, o_line2         : display rows 0 and 1
//   o_evt_clear, o_evt_cursor: command-completed strobes
//   o_err_frame              : CSN rose mid-byte
// -----------------------------------------------------------------------------
module pmod_cls_spi_responder
   import pmod_stand_spi_solo_pkg::*;
#(
   parameter int parm_sync_stages = 2
) (
   input  logic                    i_clk_20mhz,
   input  logic                    i_rst_20mhz,
   input  logic                    ei_sck,
   input  logic                    ei_csn,
   input  logic                    ei_copi,
   output logic                    eo_cipo_o,
   output logic                    eo_cipo_t,
   output logic                    o_byte_valid,
   output logic [7:0]              o_byte,
   output t_pmod_cls_ascii_line_16 o_line1,
   output t_pmod_cls_ascii_line_16 o_line2,
   output logic                    o_evt_clear,
   output logic                    o_evt_cursor,
   output logic                    o_err_frame
);

   logic       byte_valid;
   logic [7:0] byte_rx;

   pmod_spi_responder_deser #(
      .sync_stages (parm_sync_stages)
   ) u_deser (
      .clk_i        (i_clk_20mhz),
      .rst_i        (i_rst_20mhz),
      .sck_i        (ei_sck),
      .csn_i        (ei_csn),
      .copi_i       (ei_copi),
      .byte_valid_o (byte_valid),
      .byte_o       (byte_rx),
      .err_frame_o  (o_err_frame)
   );

   t_cls_state              state_q;
   logic                    row_q;
   logic [4:0]              col_q;     // 0..16; 16 means "past the end"
   logic [6:0]              p1_q;
   logic [6:0]              p2_q;
   t_pmod_cls_ascii_line_16 line1_q;
   t_pmod_cls_ascii_line_16 line2_q;
   logic                    evt_clear_q;
   logic                    evt_cursor_q;

   logic is_printable, is_digit, is_final;
   logic [3:0] col_idx;

   assign is_printable = (byte_rx >= 8'h20) && (byte_rx <= 8'h7E);
   assign is_digit     = (byte_rx >= 8'h30) && (byte_rx <= 8'h39);
   assign is_final     = (byte_rx >= 8'h40) && (byte_rx <= 8'h7E);
   // Column 0 lives in the top byte of the row vector, so index = 15 - col.
   assign col_idx      = ~col_q[3:0];

   always_ff @(posedge i_clk_20mhz) begin
      if (i_rst_20mhz) begin
         state_q      <= ST_TEXT;
         row_q        <= 1'b0;
         col_q        <= '0;
         p1_q         <= '0;
         p2_q         <= '0;
         line1_q      <= c_cls_blank_line;
         line2_q      <= c_cls_blank_line;
         evt_clear_q  <= 1'b0;
         evt_cursor_q <= 1'b0;
      end else begin
         evt_clear_q  <= 1'b0;
         evt_cursor_q <= 1'b0;
         if (byte_valid) begin
            case (state_q)
               ST_TEXT: begin
                  if (byte_rx == c_cls_esc) begin
                     state_q <= ST_ESC;
                  end else if (is_printable && (col_q < 5'(c_cls_cols))) begin
                     if (row_q) line2_q[col_idx] <= byte_rx;
                     else       line1_q[col_idx] <= byte_rx;
                     col_q <= col_q + 5'd1;
                  end
               end
               ST_ESC: begin
                  if (byte_rx == c_cls_csi) begin
                     p1_q    <= '0;
                     p2_q    <= '0;
                     state_q <= ST_CSI_P1;
                  end else begin
                     state_q <= ST_TEXT;
                  end
               end
               ST_CSI_P1, ST_CSI_P2: begin
                  if (byte_rx == c_cls_esc) begin
                     state_q <= ST_ESC;
                  end else if (is_digit) begin
                     if (state_q == ST_CSI_P1) p1_q <= f_cls_param_accum(p1_q, byte_rx[3:0]);
                     else                      p2_q <= f_cls_param_accum(p2_q, byte_rx[3:0]);
                  end else if (byte_rx == c_cls_sep) begin
                     // A second separator is ignored; we stay in P2.
                     state_q <= ST_CSI_P2;
                  end else if (byte_rx == c_cls_fin_clear) begin
                     line1_q     <= c_cls_blank_line;
                     line2_q     <= c_cls_blank_line;
                     row_q       <= 1'b0;
                     col_q       <= '0;
                     evt_clear_q <= 1'b1;
                     state_q     <= ST_TEXT;
                  end else if (byte_rx == c_cls_fin_cursor) begin
                     row_q        <= (p1_q != 7'd0);
                     col_q        <= (p2_q > 7'(c_cls_cols)) ? 5'(c_cls_cols) : p2_q[4:0];
                     evt_cursor_q <= 1'b1;
                     state_q      <= ST_TEXT;
                  end else if (is_final) begin
                     // Unsupported final byte: accepted, no effect.
                     state_q <= ST_TEXT;
                  end else begin
                     // Malformed sequence: abort.
                     state_q <= ST_TEXT;
                  end
               end
               default: state_q <= ST_TEXT;
            endcase
         end
      end
   end

   assign eo_cipo_o    = 1'b0;
   assign eo_cipo_t    = 1'b1;
   assign o_byte_valid = byte_valid;
   assign o_byte       = byte_rx;
   assign o_line1      = line1_q;
   assign o_line2      = line2_q;
   assign o_evt_clear  = evt_clear_q;
   assign o_evt_cursor = evt_cursor_q;

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Directed bench for pmod_cls_spi_responder: SPI bytes are bit-banged from a
// single initial block, display rows and strobes are compared against
// hand-written expected values.
module tb_pmod_cls_spi_responder;
   import pmod_stand_spi_solo_pkg::*;

   logic clk = 1'b0;
   logic rst, sck, csn, copi;
   logic cipo_o, cipo_t, byte_valid, evt_clear, evt_cursor, err_frame;
   logic [7:0] rx_byte;
   t_pmod_cls_ascii_line_16 line1, line2;

   int errors = 0;
   int checks = 0;
   int half   = 8;   // SCK half period in clocks
   int n_valid = 0, n_clear = 0, n_cursor = 0, n_err = 0;
   int snap;

   localparam logic [127:0] BLANK = {16{8'h20}};

   always #25 clk = ~clk;

   pmod_cls_spi_responder #(.parm_sync_stages(2)) dut (
      .i_clk_20mhz  (clk),
      .i_rst_20mhz  (rst),
      .ei_sck       (sck),
      .ei_csn       (csn),
      .ei_copi      (copi),
      .eo_cipo_o    (cipo_o),
      .eo_cipo_t    (cipo_t),
      .o_byte_valid (byte_valid),
      .o_byte       (rx_byte),
      .o_line1      (line1),
      .o_line2      (line2),
      .o_evt_clear  (evt_clear),
      .o_evt_cursor (evt_cursor),
      .o_err_frame  (err_frame)
   );

   // Strobe counters
   always @(posedge clk) begin
      if (!rst) begin
         n_valid  <= n_valid  + int'(byte_valid);
         n_clear  <= n_clear  + int'(evt_clear);
         n_cursor <= n_cursor + int'(evt_cursor);
         n_err    <= n_err    + int'(err_frame);
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic csn_lo();
      csn = 1'b0;
      tick(half);
   endtask

   task automatic csn_hi();
      csn = 1'b1;
      tick(half);
   endtask

   // One byte, MSB first; checks the strobe lands on the 3rd negedge after
   // the final SCK rise (2 sync stages + 1 register) and lasts one cycle.
   task automatic tx(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         copi = b[i];
         tick(half);
         sck = 1'b1;
         if (i == 0) begin
            for (int k = 1; k <= 4; k++) begin
               tick(1);
               if (k == 3) begin
                  chk("valid_on", 128'(byte_valid), 128'(1'b1));
                  chk("byte", 128'(rx_byte), 128'(b));
               end else begin
                  chk("valid_off", 128'(byte_valid), 128'(1'b0));
               end
            end
            tick(half - 4);
         end else begin
            tick(half);
         end
         sck = 1'b0;
      end
   endtask

   task automatic tx_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         copi = b[i];
         tick(half);
         sck = 1'b1;
         tick(half);
         sck = 1'b0;
      end
   endtask

   // n bytes, first byte in the highest used byte of data, in one CSN frame
   task automatic frame(input logic [63:0] data, input int n);
      csn_lo();
      for (int k = 0; k < n; k++) tx(data[8*(n-1-k) +: 8]);
      csn_hi();
      tick(4);
   endtask

   task automatic do_reset();
      rst = 1'b1; sck = 1'b0; csn = 1'b1; copi = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(4);
   endtask

   initial begin
      rst = 1'b1; sck = 1'b0; csn = 1'b1; copi = 1'b0;
      tick(1);
      do_reset();

      // Reset state
      chk("rst_line1", line1, BLANK);
      chk("rst_line2", line2, BLANK);
      chk("rst_byte", 128'(rx_byte), 128'(8'h00));
      chk("rst_strobes", 128'({byte_valid, evt_clear, evt_cursor, err_frame}), 128'(4'b0000));
      chk("cipo", 128'({cipo_o, cipo_t}), 128'(2'b01));

      // Text, then clear, then text lands at (0,0)
      frame(64'("Q"), 1);
      chk("q_line1", line1, {"Q", {15{8'h20}}});
      frame(64'h1B5B6A, 3);
      chk("clr_count", 128'(n_clear), 128'(1));
      chk("clr_line1", line1, BLANK);
      chk("clr_line2", line2, BLANK);
      frame(64'("K"), 1);
      chk("home_line1", line1, {"K", {15{8'h20}}});

      // Cursor (0,0) then HELLO
      frame(64'h1B5B303B3048, 6);
      frame(64'("HELLO"), 5);
      chk("hello_line1", line1, {"HELLO", {11{8'h20}}});
      chk("hello_line2", line2, BLANK);
      chk("cur_count1", 128'(n_cursor), 128'(1));

      // Cursor (1,14) then ABCD: C and D fall off the end
      frame(64'h1B5B313B313448, 7);
      frame(64'("ABCD"), 4);
      chk("abcd_line2", line2, {{14{8'h20}}, "AB"});
      chk("abcd_line1", line1, {"HELLO", {11{8'h20}}});
      chk("cur_count2", 128'(n_cursor), 128'(2));

      // Partial frame of 0xA5 (5 bits), then full 0x41 at (1,5)
      frame(64'h1B5B313B3548, 6);
      snap = n_valid;
      csn_lo();
      tx_bits(8'hA5, 5);
      csn_hi();
      tick(4);
      chk("err_count", 128'(n_err), 128'(1));
      chk("partial_novalid", 128'(n_valid), 128'(snap));
      frame(64'h41, 1);
      chk("after_err_line2", line2, {{5{8'h20}}, "A", {8{8'h20}}, "AB"});

      // Parameter saturation: 999 -> row 1, col 0
      frame(64'h1B5B393939, 5);
      frame(64'h48, 1);
      frame(64'("W"), 1);
      chk("sat_line2", line2, {"W", {4{8'h20}}, "A", {8{8'h20}}, "AB"});
      chk("cur_count4", 128'(n_cursor), 128'(4));

      // Unknown final 'h' is a no-op, LF ignored, then 'x' at col 1
      frame(64'h1B5B32680A78, 6);
      chk("noop_line2", line2, {"Wx", {3{8'h20}}, "A", {8{8'h20}}, "AB"});
      chk("noop_cursor", 128'(n_cursor), 128'(4));

      // Column 20 clamps to 16: next char is discarded
      frame(64'h1B5B303B323048, 7);
      frame(64'("Y"), 1);
      chk("clamp_line1", line1, {"HELLO", {11{8'h20}}});
      chk("cur_count5", 128'(n_cursor), 128'(5));

      // Reset mid-sequence and mid-byte
      csn_lo();
      tx(8'h1B); tx(8'h5B); tx(8'h31);
      tx_bits(8'hFF, 3);
      do_reset();
      chk("mid_rst_line1", line1, BLANK);
      chk("mid_rst_line2", line2, BLANK);
      chk("mid_rst_byte", 128'(rx_byte), 128'(8'h00));
      frame(64'("Z"), 1);
      chk("z_line1", line1, {"Z", {15{8'h20}}});
      chk("z_line2", line2, BLANK);
      chk("z_cursor", 128'(n_cursor), 128'(5));

      // Clear split across two frames at SCK = clk/32
      half = 16;
      frame(64'h1B, 1);
      frame(64'h5B6A, 2);
      chk("split_clear", 128'(n_clear), 128'(2));
      chk("split_line1", line1, BLANK);
      chk("split_line2", line2, BLANK);
      chk("err_final", 128'(n_err), 128'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
